mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multicycle data-memory access unit between the processor control FSM/datapath and a synchronous single-port data memory. Accepts one load or store request at a time (word, halfword, byte), performs the memory read, lane extraction with sign extension, or read-modify-write merge for sub-word stores. Returns the load value for the MDR plus a one-cycle `done` pulse. Size encoding matches the controller's `adjsz_ctrl`.

## Interface
- `ADDR_W`, 32, byte-address width
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request strobe, sampled only in IDLE
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = word, 1 = byte, 2 = half, 3 = reserved (treated as word)
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data; sub-word data is in the low bits
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at request completion
- `err`  out  1  valid with `done`; misaligned request
- `rdata`  out  32  sign-extended load result, held until the next load completes
- `mem_addr`  out  ADDR_W-2  word address to memory
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, valid one cycle after the address is presented

## Operation
- States:
  - IDLE
  - RD: drive address, read
  - CAP: capture `mem_rdata`
  - WR: drive `mem_we`
  - DONE: pulse `done`
- IDLE with `req_valid`: latch `write`, `size`, `addr`, `wdata`.
  - Misaligned request: go to DONE with `err` = 1.
  - Word store: go to WR.
  - Otherwise: go to RD.
- RD → CAP, unconditionally.
- CAP: capture `mem_rdata` into the merge register.
  - Load: compute `rdata` and go to DONE.
  - Sub-word store: go to WR.
- WR: `mem_we` = 1; `mem_wdata` is the merged word (or `req_wdata` for a word store). WR → DONE.
- DONE: `done` = 1, `err` as latched. DONE → IDLE.
- Little-endian lanes:
  - Byte lane = `addr[1:0]`; byte 0 occupies bits [7:0].
  - Half lane = `addr[1]`.
- Loads: the selected lane is sign-extended to 32 bits.
- Sub-word stores replace only the selected lane; the other lanes keep the value read in CAP.
- Misaligned: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0. No memory access occurs and `rdata` is unchanged.
- `req_valid` outside IDLE is ignored; no queuing.
- `mem_addr` = `addr[ADDR_W-1:2]` in RD and WR, 0 elsewhere.
- `mem_we` is high only in WR.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `mem_we` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
- Latency from the accept edge to `done` high:
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
  - Word store: 2 cycles.
  - Misaligned: 1 cycle.
- `busy` rises in the cycle after the accept edge. It falls in the cycle after DONE, so a new request is accepted at the earliest one cycle after `done`.
- `rdata` updates on the same edge that enters DONE.
- Reset asserted mid-operation: the transaction is abandoned and `mem_we` drops immediately, asynchronously. No partial write occurs unless reset lands after the WR edge.

## Configuration
- `MAU_MISALIGN_TRAP_EN` defined: misaligned requests behave as described above (`err` = 1, no memory access).
- Undefined:
  - `err` is tied to 0.
  - Misaligned addresses are silently aligned: the low bit is forced to 0 for half, the low two bits for word.
  - The request then proceeds normally.

## Structure
- Package `mau_pkg` holds:
  - Size constants `SZ_WORD` = 2'd0, `SZ_BYTE` = 2'd1, `SZ_HALF` = 2'd2.
  - The state enum.
- Sub-module `mau_lane_align` (combinational) provides:
  - Load extraction and sign extension from word + addr[1:0] + size.
  - Store merge from old word + new data + addr[1:0] + size.

## Test plan
- Memory word 0x100 = 0x8899AABB; load byte at 0x101 → `done` 3 cycles after accept, `rdata` = 0xFFFFFFAA, `mem_we` never high.
- Load half at 0x102 with the same word → `rdata` = 0xFFFF8899; then load byte at 0x100 → `rdata` = 0xFFFFFFBB.
- Store byte 0x11 at 0x103 over 0x8899AABB → a single `mem_we` pulse with `mem_wdata` = 0x1199AABB at `mem_addr` 0x40; `done` 4 cycles after accept.
- Store word 0xDEADBEEF at 0x200 → no read cycle, WR in the cycle after accept, `done` 2 cycles after accept.
- Load word at 0x102 with the macro defined → `done` and `err` high the cycle after accept, no memory access, `rdata` unchanged. Without the macro → reads 0x100, `err` = 0.
- Assert `rst_n` low during CAP of a sub-word store → `mem_we` never pulses, `busy` = 0, memory unchanged. A new request accepted after release completes normally.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared constants for the memory access unit.
//   SZ_*        request size encodings (same as the controller's adjsz_ctrl)
//   mau_state_e access sequencer state encoding
package mau_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } mau_state_e;

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational little-endian lane handling.
//   ld_word  in  32  word read from memory
//   st_old   in  32  word captured for read-modify-write
//   st_data  in  32  store data, sub-word data in the low bits
//   lane     in  2   byte address bits [1:0]
//   size     in  2   SZ_WORD / SZ_BYTE / SZ_HALF
//   ld_val   out 32  selected lane, sign-extended
//   st_word  out 32  st_old with the selected lane replaced
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [31:0] st_old,
    input  logic [31:0] st_data,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    output logic [31:0] ld_val,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];

        case (size)
            SZ_BYTE: ld_val = {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = {{16{ld_half[15]}}, ld_half};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    st_word[7:0]   = st_data[7:0];
                    2'd1:    st_word[15:8]  = st_data[7:0];
                    2'd2:    st_word[23:16] = st_data[7:0];
                    default: st_word[31:24] = st_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) st_word[31:16] = st_data[15:0];
                else         st_word[15:0]  = st_data[15:0];
            end
            default: st_word = st_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle load/store sequencer in front of a synchronous
// single-port data memory (read data valid one cycle after the address).
//   clk, rst_n                  clock, async active-low reset
//   req_valid/write/size/addr/wdata   request, sampled only when idle
//   busy, done, err, rdata      status and sign-extended load result
//   mem_addr, mem_we, mem_wdata, mem_rdata   word-addressed memory port
// Build option MAU_MISALIGN_TRAP_EN: when defined, misaligned requests finish
// immediately with err and no memory access; otherwise the address is
// silently aligned and err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for req_valid
// ST_RD   | word address driven, memory read in flight
// ST_CAP  | mem_rdata valid; capture for load or merge
// ST_WR   | mem_we high with final word
// ST_DONE | done pulse, err valid
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    mau_state_e        state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic [1:0]        acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_err;
    logic [31:0]       ld_val;
    logic [31:0]       st_word;

    // Request qualification: reserved size folds to word, then either flag
    // or silently repair misalignment depending on the build.
    always_comb begin
        acc_size = (req_size == 2'd3) ? SZ_WORD : req_size;
        acc_addr = req_addr;
        acc_err  = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
        if (acc_size == SZ_HALF)      acc_err = req_addr[0];
        else if (acc_size == SZ_WORD) acc_err = |req_addr[1:0];
`else
        if (acc_size == SZ_HALF)      acc_addr[0]   = 1'b0;
        else if (acc_size == SZ_WORD) acc_addr[1:0] = 2'b00;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (acc_err)                                state_d = ST_DONE;
                    else if (req_write && acc_size == SZ_WORD) state_d = ST_WR;
                    else                                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = write_q ? ST_WR : ST_DONE;
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                write_q <= req_write;
                size_q  <= acc_size;
                addr_q  <= acc_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_CAP) begin
                merge_q <= mem_rdata;
                if (!write_q) rdata_q <= ld_val;
            end
        end
    end

`ifdef MAU_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            err_q <= 1'b0;
        else if (state_q == ST_IDLE && req_valid) err_q <= acc_err;
    end

    assign err = (state_q == ST_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    // Loads extract straight from mem_rdata in CAP; stores merge against the
    // word captured in CAP, which is stable throughout WR.
    mau_lane_align u_lane_align (
        .ld_word (mem_rdata),
        .st_old  (merge_q),
        .st_data (wdata_q),
        .lane    (addr_q[1:0]),
        .size    (size_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    // Outputs decode directly from state so reset clears mem_we asynchronously.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_we    = (state_q == ST_WR);
    assign mem_wdata = mem_we ? st_word : 32'd0;
    assign mem_addr  = (state_q == ST_RD || state_q == ST_WR) ? addr_q[ADDR_W-1:2] : '0;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous single-port memory model with a bench preload port.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one request and observe it until done (bounded to 20 cycles).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int we_cnt,
                          output int rd_cnt, output logic [31:0] we_data,
                          output logic [29:0] we_addr, output logic err_seen,
                          output logic busy_first, output logic busy_after);
        lat = -1; we_cnt = 0; rd_cnt = 0; we_data = 32'd0; we_addr = 30'd0;
        err_seen = 1'b0; busy_first = 1'b0; busy_after = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 1) busy_first = busy;
            if (mem_we) begin
                we_cnt++; we_data = mem_wdata; we_addr = mem_addr;
            end else if (mem_addr != 30'd0) begin
                rd_cnt++;
            end
            if (done) begin
                lat = k; err_seen = err;
                break;
            end
        end
        @(negedge clk);
        busy_after = busy;
    endtask

    int          lat, we_cnt, rd_cnt;
    logic [31:0] we_data;
    logic [29:0] we_addr;
    logic        err_seen, busy_first, busy_after;

    task automatic test_reset();
        preload(8'h40, 32'h8899AABB);
        preload(8'h80, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_cmp++; if (rdata !== 32'd0)     begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        n_cmp++; if (mem_addr !== 30'd0)  begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    endtask

    task automatic test_load_byte();
        do_req(1'b0, 2'd1, 32'h101, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (lat !== 3)             begin n_bad++; $display("FAIL ldb_latency: got %0d expected 3", lat); end
        n_cmp++; if (rdata !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL ldb_rdata: got %h expected ffffffaa", rdata); end
        n_cmp++; if (we_cnt !== 0)          begin n_bad++; $display("FAIL ldb_no_write: got %0d expected 0", we_cnt); end
        n_cmp++; if (rd_cnt !== 1)          begin n_bad++; $display("FAIL ldb_read_cycles: got %0d expected 1", rd_cnt); end
        n_cmp++; if (busy_first !== 1'b1)   begin n_bad++; $display("FAIL ldb_busy_rise: got %b expected 1", busy_first); end
        n_cmp++; if (busy_after !== 1'b0)   begin n_bad++; $display("FAIL ldb_busy_fall: got %b expected 0", busy_after); end
    endtask

    task automatic test_load_half();
        do_req(1'b0, 2'd2, 32'h102, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (rdata !== 32'hFFFF8899) begin n_bad++; $display("FAIL ldh_rdata: got %h expected ffff8899", rdata); end
        n_cmp++; if (lat !== 3)              begin n_bad++; $display("FAIL ldh_latency: got %0d expected 3", lat); end
        do_req(1'b0, 2'd1, 32'h100, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (rdata !== 32'hFFFFFFBB) begin n_bad++; $display("FAIL ldb0_rdata: got %h expected ffffffbb", rdata); end
    endtask

    task automatic test_store_byte();
        do_req(1'b1, 2'd1, 32'h103, 32'h00000011, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (lat !== 4)               begin n_bad++; $display("FAIL stb_latency: got %0d expected 4", lat); end
        n_cmp++; if (we_cnt !== 1)            begin n_bad++; $display("FAIL stb_we_pulses: got %0d expected 1", we_cnt); end
        n_cmp++; if (we_data !== 32'h1199AABB) begin n_bad++; $display("FAIL stb_wdata: got %h expected 1199aabb", we_data); end
        n_cmp++; if (we_addr !== 30'h40)      begin n_bad++; $display("FAIL stb_waddr: got %h expected 40", we_addr); end
        n_cmp++; if (mem[8'h40] !== 32'h1199AABB) begin n_bad++; $display("FAIL stb_mem: got %h expected 1199aabb", mem[8'h40]); end
        n_cmp++; if (rdata !== 32'hFFFFFFBB)  begin n_bad++; $display("FAIL stb_rdata_hold: got %h expected ffffffbb", rdata); end
    endtask

    task automatic test_store_word();
        do_req(1'b1, 2'd0, 32'h200, 32'hDEADBEEF, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (lat !== 2)               begin n_bad++; $display("FAIL stw_latency: got %0d expected 2", lat); end
        n_cmp++; if (rd_cnt !== 0)            begin n_bad++; $display("FAIL stw_no_read: got %0d expected 0", rd_cnt); end
        n_cmp++; if (we_cnt !== 1)            begin n_bad++; $display("FAIL stw_we_pulses: got %0d expected 1", we_cnt); end
        n_cmp++; if (we_addr !== 30'h80)      begin n_bad++; $display("FAIL stw_waddr: got %h expected 80", we_addr); end
        n_cmp++; if (mem[8'h80] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stw_mem: got %h expected deadbeef", mem[8'h80]); end
    endtask

    task automatic test_store_half();
        do_req(1'b1, 2'd2, 32'h202, 32'hFFFF1234, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (lat !== 4)               begin n_bad++; $display("FAIL sth_latency: got %0d expected 4", lat); end
        n_cmp++; if (we_data !== 32'h1234BEEF) begin n_bad++; $display("FAIL sth_wdata: got %h expected 1234beef", we_data); end
        do_req(1'b0, 2'd2, 32'h200, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (rdata !== 32'hFFFFBEEF)  begin n_bad++; $display("FAIL ldh0_rdata: got %h expected ffffbeef", rdata); end
        do_req(1'b0, 2'd1, 32'h203, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (rdata !== 32'h00000012)  begin n_bad++; $display("FAIL ldb3_rdata: got %h expected 00000012", rdata); end
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 2'd0, 32'h102, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
`ifdef MAU_MISALIGN_TRAP_EN
        n_cmp++; if (lat !== 1)              begin n_bad++; $display("FAIL mis_latency: got %0d expected 1", lat); end
        n_cmp++; if (err_seen !== 1'b1)      begin n_bad++; $display("FAIL mis_err: got %b expected 1", err_seen); end
        n_cmp++; if (rd_cnt !== 0)           begin n_bad++; $display("FAIL mis_no_read: got %0d expected 0", rd_cnt); end
        n_cmp++; if (rdata !== 32'h00000012) begin n_bad++; $display("FAIL mis_rdata_hold: got %h expected 00000012", rdata); end
`else
        n_cmp++; if (lat !== 3)              begin n_bad++; $display("FAIL mis_latency: got %0d expected 3", lat); end
        n_cmp++; if (err_seen !== 1'b0)      begin n_bad++; $display("FAIL mis_err: got %b expected 0", err_seen); end
        n_cmp++; if (rdata !== 32'h1199AABB) begin n_bad++; $display("FAIL mis_rdata: got %h expected 1199aabb", rdata); end
`endif
        n_cmp++; if (we_cnt !== 0)           begin n_bad++; $display("FAIL mis_no_write: got %0d expected 0", we_cnt); end
        do_req(1'b0, 2'd3, 32'h200, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (rdata !== 32'h1234BEEF) begin n_bad++; $display("FAIL rsv_size_rdata: got %h expected 1234beef", rdata); end
        n_cmp++; if (lat !== 3)              begin n_bad++; $display("FAIL rsv_size_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_addr = 32'h101; req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_we) we_seen++;
        @(negedge clk);
        if (mem_we) we_seen++;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_we: got %b expected 0", mem_we); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        n_cmp++; if (we_seen !== 0)              begin n_bad++; $display("FAIL rmid_we_pulses: got %0d expected 0", we_seen); end
        n_cmp++; if (mem[8'h40] !== 32'h1199AABB) begin n_bad++; $display("FAIL rmid_mem: got %h expected 1199aabb", mem[8'h40]); end
        n_cmp++; if (rdata !== 32'd0)            begin n_bad++; $display("FAIL rmid_rdata: got %h expected 0", rdata); end
        do_req(1'b0, 2'd1, 32'h101, 32'd0, lat, we_cnt, rd_cnt, we_data, we_addr, err_seen, busy_first, busy_after);
        n_cmp++; if (lat !== 3)              begin n_bad++; $display("FAIL rmid_next_latency: got %0d expected 3", lat); end
        n_cmp++; if (rdata !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL rmid_next_rdata: got %h expected ffffffaa", rdata); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_store_word();
        test_store_half();
        test_misaligned();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
